// File: rtl/shift_operand_sequencer_pkg.sv
// Shared constants for the operand-2 sequencer: shift kinds, amount-source flag,
// FSM state encoding and instruction field positions.
package shift_operand_sequencer_pkg;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    localparam logic REG_AMT = 1'b1;
    localparam logic IMM_AMT = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_RM  = 3'd1,
        CAP_RM = 3'd2,
        RD_RS  = 3'd3,
        CAP_RS = 3'd4,
        SHIFT  = 3'd5,
        HOLD   = 3'd6
    } state_t;

    // Positions within the instruction; everything below I_BIT lives in the 12-bit operand-2 field.
    localparam int I_BIT     = 25;
    localparam int ROT_MSB   = 11;
    localparam int ROT_LSB   = 8;
    localparam int RS_MSB    = 11;
    localparam int RS_LSB    = 8;
    localparam int AMT_MSB   = 11;
    localparam int AMT_LSB   = 7;
    localparam int TYPE_MSB  = 6;
    localparam int TYPE_LSB  = 5;
    localparam int REG_SHIFT = 4;
    localparam int RM_MSB    = 3;
    localparam int RM_LSB    = 0;
    localparam int IMM_MSB   = 7;

endpackage

// File: rtl/shift_operand_sequencer_barrel_shifter.sv
// barrelShifter: combinational ARM-style shifter with immediate-amount special
// encodings (LSR/ASR #0 = #32, ROR #0 = RRX) and register-amount semantics.
module barrelShifter
    import shift_operand_sequencer_pkg::*;
(
    input  logic [31:0] Shift_Data,
    input  logic [7:0]  Shift_Num,
    input  logic [2:0]  SHFT_OP,
    input  logic        Carry_flag,
    output logic [31:0] Shift_Out,
    output logic        Shift_Carry_Out
);

    logic [1:0]  kind;
    logic [7:0]  amt;
    logic [32:0] ext;
    logic [31:0] rot;

    assign kind = SHFT_OP[2:1];

    // Extended 33-bit shifts put the last bit shifted out in the spare position.
    always_comb begin
        Shift_Out       = Shift_Data;
        Shift_Carry_Out = Carry_flag;
        amt             = Shift_Num;
        ext             = '0;
        rot             = '0;
        if (SHFT_OP[0] == IMM_AMT) begin
            amt = {3'b000, Shift_Num[4:0]};
            if (Shift_Num[4:0] == 5'd0 && (kind == LSR || kind == ASR)) begin
                amt = 8'd32;
            end
        end
        if (SHFT_OP[0] == IMM_AMT && kind == ROR && Shift_Num[4:0] == 5'd0) begin
            Shift_Out       = {Carry_flag, Shift_Data[31:1]};
            Shift_Carry_Out = Shift_Data[0];
        end else if (amt != 8'd0) begin
            case (kind)
                LSL: begin
                    ext             = {1'b0, Shift_Data} << amt;
                    Shift_Out       = ext[31:0];
                    Shift_Carry_Out = ext[32];
                end
                LSR: begin
                    ext             = {Shift_Data, 1'b0} >> amt;
                    Shift_Out       = ext[32:1];
                    Shift_Carry_Out = ext[0];
                end
                ASR: begin
                    ext             = $signed({Shift_Data, 1'b0}) >>> amt;
                    Shift_Out       = ext[32:1];
                    Shift_Carry_Out = ext[0];
                end
                default: begin
                    rot             = 32'({Shift_Data, Shift_Data} >> amt[4:0]);
                    Shift_Out       = rot;
                    Shift_Carry_Out = rot[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_operand_sequencer.sv
// Multi-cycle operand-2 sequencer: fetches Rm/Rs through one synchronous read port,
// drives barrelShifter and holds the registered result behind a valid/ready handshake.
module shift_operand_sequencer
    import shift_operand_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Inst_Valid,
    output logic              Inst_Ready,
    input  logic [31:0]       Inst,
    input  logic              Carry_flag,
    output logic              Rd_En,
    output logic [REG_AW-1:0] Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Op2_Valid,
    input  logic              Op2_Ready,
    output logic [DATA_W-1:0] Op2,
    output logic              Op2_Carry
);

    state_t            state_q, state_d;
    logic              i_q;
    logic [11:0]       field_q;
    logic              c_lat;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        num_q;

    logic [DATA_W-1:0] shift_data;
    logic [7:0]        shift_num;
    logic [2:0]        shft_op;
    logic              use_c_lat;
    logic [DATA_W-1:0] shift_out;
    logic              shift_carry;

    logic unused_inst_bits;
    assign unused_inst_bits = ^{Inst[31:26], Inst[24:12]};

    always_comb begin
        state_d    = state_q;
        Inst_Ready = 1'b0;
        Rd_En      = 1'b0;
        Rd_Addr    = '0;
        case (state_q)
            IDLE: begin
                Inst_Ready = 1'b1;
                if (Inst_Valid) state_d = Inst[I_BIT] ? SHIFT : RD_RM;
            end
            RD_RM: begin
                Rd_En   = 1'b1;
                Rd_Addr = REG_AW'(field_q[RM_MSB:RM_LSB]);
                state_d = field_q[REG_SHIFT] ? RD_RS : CAP_RM;
            end
            RD_RS: begin
                Rd_En   = 1'b1;
                Rd_Addr = REG_AW'(field_q[RS_MSB:RS_LSB]);
                state_d = CAP_RS;
            end
            CAP_RM, CAP_RS: state_d = SHIFT;
            SHIFT:          state_d = HOLD;
            HOLD:           if (Op2_Ready) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    assign Op2_Valid = (state_q == HOLD);

    // A zero effective amount without a special encoding keeps the latched CPSR carry.
    always_comb begin
        shift_data = data_q;
        shift_num  = '0;
        shft_op    = {LSL, IMM_AMT};
        use_c_lat  = 1'b0;
        if (i_q) begin
            shift_data = {{(DATA_W-8){1'b0}}, field_q[IMM_MSB:0]};
            shift_num  = {3'b000, field_q[ROT_MSB:ROT_LSB], 1'b0};
            shft_op    = {ROR, REG_AMT};
            use_c_lat  = (field_q[ROT_MSB:ROT_LSB] == 4'd0);
        end else if (field_q[REG_SHIFT]) begin
            shift_num  = num_q;
            shft_op    = {field_q[TYPE_MSB:TYPE_LSB], REG_AMT};
            use_c_lat  = (num_q == 8'd0);
        end else begin
            shift_num  = {3'b000, field_q[AMT_MSB:AMT_LSB]};
            shft_op    = {field_q[TYPE_MSB:TYPE_LSB], IMM_AMT};
            use_c_lat  = (field_q[TYPE_MSB:TYPE_LSB] == LSL) &&
                         (field_q[AMT_MSB:AMT_LSB] == 5'd0);
        end
    end

    barrelShifter u_shifter (
        .Shift_Data      (shift_data),
        .Shift_Num       (shift_num),
        .SHFT_OP         (shft_op),
        .Carry_flag      (c_lat),
        .Shift_Out       (shift_out),
        .Shift_Carry_Out (shift_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_q       <= 1'b0;
            field_q   <= '0;
            c_lat     <= 1'b0;
            data_q    <= '0;
            num_q     <= '0;
            Op2       <= '0;
            Op2_Carry <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (Inst_Valid) begin
                        i_q     <= Inst[I_BIT];
                        field_q <= Inst[11:0];
                        c_lat   <= Carry_flag;
                    end
                end
                RD_RS, CAP_RM: data_q <= Rd_Data;
                CAP_RS:        num_q  <= Rd_Data[7:0];
                SHIFT: begin
                    Op2       <= shift_out;
                    Op2_Carry <= use_c_lat ? c_lat : shift_carry;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Directed self-checking bench for shift_operand_sequencer with a one-cycle-latency
// register-file model behind the read port.
module tb_shift_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Inst;
    logic        Carry_flag;
    logic        Rd_En;
    logic [3:0]  Rd_Addr;
    logic [31:0] Rd_Data;
    logic        Op2_Valid;
    logic        Op2_Ready;
    logic [31:0] Op2;
    logic        Op2_Carry;

    int checks = 0;
    int fails  = 0;

    logic [31:0] regs [16];

    shift_operand_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Inst_Valid (Inst_Valid),
        .Inst_Ready (Inst_Ready),
        .Inst       (Inst),
        .Carry_flag (Carry_flag),
        .Rd_En      (Rd_En),
        .Rd_Addr    (Rd_Addr),
        .Rd_Data    (Rd_Data),
        .Op2_Valid  (Op2_Valid),
        .Op2_Ready  (Op2_Ready),
        .Op2        (Op2),
        .Op2_Carry  (Op2_Carry)
    );

    always #5 clk = ~clk;

    // Read data is only defined in the cycle after a strobe.
    always @(posedge clk) Rd_Data <= Rd_En ? regs[Rd_Addr] : 'x;

    task automatic send_inst(input logic [31:0] inst, input logic c,
                             output int lat, output logic saw_rd);
        @(negedge clk);
        Inst       = inst;
        Carry_flag = c;
        Inst_Valid = 1'b1;
        saw_rd     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        Inst_Valid = 1'b0;
        Inst       = $urandom;
        Carry_flag = ~c;
        lat        = 1;
        while (Op2_Valid !== 1'b1 && lat < 20) begin
            saw_rd = saw_rd | (Rd_En === 1'b1);
            @(negedge clk);
            lat++;
        end
        if (Op2_Valid !== 1'b1) lat = -1;
    endtask

    task automatic release_op2();
        Op2_Ready = 1'b1;
        @(negedge clk);
        Op2_Ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        Inst_Valid = 1'b0;
        Op2_Ready  = 1'b0;
        Inst       = '0;
        Carry_flag = 1'b0;
        #3;
        checks++;
        if (Inst_Ready !== 1'b1) begin fails++; $display("FAIL reset_inst_ready got=%b want=1", Inst_Ready); end
        checks++;
        if (Rd_En !== 1'b0 || Rd_Addr !== 4'd0) begin fails++; $display("FAIL reset_rd got en=%b addr=%h want en=0 addr=0", Rd_En, Rd_Addr); end
        checks++;
        if (Op2_Valid !== 1'b0 || Op2 !== 32'h0 || Op2_Carry !== 1'b0) begin
            fails++; $display("FAIL reset_op2 got v=%b op2=%h c=%b want 0/0/0", Op2_Valid, Op2, Op2_Carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_immediate();
        int   lat;
        logic saw_rd;
        send_inst(32'h0200_01FF, 1'b0, lat, saw_rd);
        checks++;
        if (lat != 2) begin fails++; $display("FAIL imm_latency got=%0d want=2", lat); end
        checks++;
        if (saw_rd !== 1'b0) begin fails++; $display("FAIL imm_no_read got=%b want=0", saw_rd); end
        checks++;
        if (Op2 !== 32'hC000_003F || Op2_Carry !== 1'b1) begin
            fails++; $display("FAIL imm_result got=%h/%b want=c000003f/1", Op2, Op2_Carry);
        end
        release_op2();
        checks++;
        if (Inst_Ready !== 1'b1 || Op2_Valid !== 1'b0) begin
            fails++; $display("FAIL imm_release got ready=%b valid=%b want 1/0", Inst_Ready, Op2_Valid);
        end
    endtask

    task automatic test_imm_shift();
        logic [31:0] insts [5] = '{32'h021, 32'h062, 32'h041, 32'h207, 32'h007};
        logic        cins  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] exps  [5] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5A5A_5A50, 32'hA5A5_A5A5};
        logic        expcs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   lat;
        logic saw_rd;
        for (int k = 0; k < 5; k++) begin
            send_inst(insts[k], cins[k], lat, saw_rd);
            checks++;
            if (lat != 4) begin fails++; $display("FAIL imm_shift_latency[%0d] got=%0d want=4", k, lat); end
            checks++;
            if (Op2 !== exps[k] || Op2_Carry !== expcs[k]) begin
                fails++; $display("FAIL imm_shift_result[%0d] got=%h/%b want=%h/%b", k, Op2, Op2_Carry, exps[k], expcs[k]);
            end
            release_op2();
        end
    endtask

    task automatic test_reg_shift();
        logic [31:0] insts [3] = '{32'h0000_A3F4, 32'h0000_0516, 32'h0000_0831};
        logic        cins  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [3] = '{32'h7812_3456, 32'hDEAD_BEEF, 32'h0000_0000};
        logic        expcs [3] = '{1'b0, 1'b1, 1'b1};
        int   lat;
        logic saw_rd;
        for (int k = 0; k < 3; k++) begin
            send_inst(insts[k], cins[k], lat, saw_rd);
            checks++;
            if (lat != 5) begin fails++; $display("FAIL reg_shift_latency[%0d] got=%0d want=5", k, lat); end
            checks++;
            if (Op2 !== exps[k] || Op2_Carry !== expcs[k]) begin
                fails++; $display("FAIL reg_shift_result[%0d] got=%h/%b want=%h/%b", k, Op2, Op2_Carry, exps[k], expcs[k]);
            end
            release_op2();
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic saw_rd;
        send_inst(32'h0200_005A, 1'b1, lat, saw_rd);
        checks++;
        if (lat != 2 || Op2 !== 32'h0000_005A || Op2_Carry !== 1'b1) begin
            fails++; $display("FAIL bp_first got lat=%0d op2=%h c=%b want 2/0000005a/1", lat, Op2, Op2_Carry);
        end
        for (int k = 0; k < 3; k++) begin
            Inst       = 32'h0200_01FF;
            Carry_flag = 1'b0;
            Inst_Valid = (k != 1);
            @(negedge clk);
            checks++;
            if (Op2_Valid !== 1'b1 || Inst_Ready !== 1'b0 || Op2 !== 32'h0000_005A || Op2_Carry !== 1'b1) begin
                fails++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b op2=%h c=%b want 1/0/0000005a/1", k, Op2_Valid, Inst_Ready, Op2, Op2_Carry);
            end
        end
        Op2_Ready = 1'b1;
        @(negedge clk);
        Op2_Ready = 1'b0;
        checks++;
        if (Inst_Ready !== 1'b1 || Op2_Valid !== 1'b0) begin
            fails++; $display("FAIL bp_handshake got rdy=%b v=%b want 1/0", Inst_Ready, Op2_Valid);
        end
        Inst_Valid = 1'b0;
        send_inst(32'h0200_0201, 1'b1, lat, saw_rd);
        checks++;
        if (lat != 2 || Op2 !== 32'h1000_0000 || Op2_Carry !== 1'b0) begin
            fails++; $display("FAIL bp_next got lat=%0d op2=%h c=%b want 2/10000000/0", lat, Op2, Op2_Carry);
        end
        release_op2();
    endtask

    task automatic test_reset_midflight();
        int   lat;
        logic saw_rd;
        @(negedge clk);
        Inst       = 32'h0000_A3F4;
        Carry_flag = 1'b0;
        Inst_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Inst_Valid = 1'b0;
        @(negedge clk);
        checks++;
        if (Rd_En !== 1'b1 || Rd_Addr !== 4'd3) begin
            fails++; $display("FAIL rst_mid_in_rd_rs got en=%b addr=%h want 1/3", Rd_En, Rd_Addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (Rd_En !== 1'b0 || Op2_Valid !== 1'b0 || Op2 !== 32'h0 || Op2_Carry !== 1'b0) begin
            fails++; $display("FAIL rst_mid_async got en=%b v=%b op2=%h c=%b want 0/0/0/0", Rd_En, Op2_Valid, Op2, Op2_Carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (Inst_Ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got=%b want=1", Inst_Ready); end
        send_inst(32'h0000_A3F4, 1'b1, lat, saw_rd);
        checks++;
        if (lat != 5 || Op2 !== 32'h7812_3456 || Op2_Carry !== 1'b0) begin
            fails++; $display("FAIL rst_mid_recover got lat=%0d op2=%h c=%b want 5/78123456/0", lat, Op2, Op2_Carry);
        end
        release_op2();
    endtask

    initial begin
        foreach (regs[i]) regs[i] = 32'h0;
        regs[1] = 32'h8000_0000;
        regs[2] = 32'h0000_0001;
        regs[3] = 32'h0000_0008;
        regs[4] = 32'h1234_5678;
        regs[5] = 32'h0000_0F00;
        regs[6] = 32'hDEAD_BEEF;
        regs[7] = 32'hA5A5_A5A5;
        regs[8] = 32'h0000_0020;

        test_reset();
        test_immediate();
        test_imm_shift();
        test_reg_shift();
        test_back_to_back();
        test_reset_midflight();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
